// File: rtl/mtf_encoder.sv
// Move-to-front encoder for BWT output: one symbol per cycle in, rank out one cycle later.
// No backpressure; the table resets to identity at each block boundary, on clear and on rst.
module mtf_encoder #(
    parameter int STRING_LEN = 128,
    parameter int ALPHABET   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       valid_in,
    input  logic [7:0] char_in,
    output logic [7:0] index_out,
    output logic       valid_out,
    output logic       last_out
);

    localparam int CW = (STRING_LEN > 2) ? $clog2(STRING_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STRING_LEN - 1);

    logic [7:0]          r_tab [ALPHABET];
    logic [CW-1:0]       r_cnt;
    logic [7:0]          r_index;
    logic                r_valid;
    logic                r_last;

    logic [ALPHABET-1:0] w_hit;
    logic [ALPHABET-1:0] w_shift;
    logic [7:0]          w_k;
    logic                w_block_end;

    // Exactly one entry matches because the table is always a permutation.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < ALPHABET; i++) begin
            w_hit[i] = (r_tab[i] == char_in);
        end
    end

    always_comb begin
        w_k = 8'd0;
        for (int i = 0; i < ALPHABET; i++) begin
            w_k = w_k | (w_hit[i] ? 8'(i) : 8'd0);
        end
    end

    always_comb begin
        w_shift = '0;
        for (int i = 0; i < ALPHABET; i++) begin
            w_shift[i] = (8'(i) <= w_k);
        end
    end

    assign w_block_end = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ALPHABET; i++) begin
                r_tab[i] <= 8'(i);
            end
            r_cnt   <= '0;
            r_index <= 8'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < ALPHABET; i++) begin
                r_tab[i] <= 8'(i);
            end
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (valid_in) begin
            r_index <= w_k;
            r_valid <= 1'b1;
            if (w_block_end) begin
                // Next block must start from identity, so the shift is skipped here.
                for (int i = 0; i < ALPHABET; i++) begin
                    r_tab[i] <= 8'(i);
                end
                r_cnt  <= '0;
                r_last <= 1'b1;
            end else begin
                r_tab[0] <= char_in;
                for (int i = 1; i < ALPHABET; i++) begin
                    if (w_shift[i]) begin
                        r_tab[i] <= r_tab[i-1];
                    end
                end
                r_cnt  <= r_cnt + 1'b1;
                r_last <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign index_out = r_index;
    assign valid_out = r_valid;
    assign last_out  = r_last;

endmodule

// File: tb/tb_mtf_encoder.sv
// Bench for mtf_encoder with 4-symbol blocks; reference is a list-based move-to-front model.
module tb_mtf_encoder;

    localparam int SL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] char_in = 8'd0;
    logic [7:0] index_out;
    logic       valid_out;
    logic       last_out;

    int checks = 0;
    int failures = 0;

    int         m_list[$];
    int         m_cnt;
    logic [7:0] e_idx;
    logic       e_vld;
    logic       e_last;

    mtf_encoder #(.STRING_LEN(SL)) dut (
        .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in),
        .char_in(char_in), .index_out(index_out), .valid_out(valid_out), .last_out(last_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void m_identity();
        m_list.delete();
        for (int i = 0; i < 256; i++) m_list.push_back(i);
    endfunction

    function automatic void m_reset();
        m_identity();
        m_cnt  = 0;
        e_idx  = 8'd0;
        e_vld  = 1'b0;
        e_last = 1'b0;
    endfunction

    function automatic void m_step(input logic v, input logic [7:0] ch, input logic clr);
        int k;
        if (clr) begin
            m_identity();
            m_cnt  = 0;
            e_vld  = 1'b0;
            e_last = 1'b0;
        end else if (v) begin
            k = 0;
            for (int i = 0; i < 256; i++) if (m_list[i] == int'(ch)) k = i;
            e_idx = 8'(k);
            e_vld = 1'b1;
            if (m_cnt == SL - 1) begin
                e_last = 1'b1;
                m_cnt  = 0;
                m_identity();
            end else begin
                e_last = 1'b0;
                m_cnt  = m_cnt + 1;
                m_list.delete(k);
                m_list.push_front(int'(ch));
            end
        end else begin
            e_vld  = 1'b0;
            e_last = 1'b0;
        end
    endfunction

    // Presents one cycle of inputs, advances the model, returns at posedge+1 with inputs idle.
    task automatic drive(input logic v, input logic [7:0] ch, input logic clr);
        valid_in = v;
        char_in  = ch;
        clear    = clr;
        @(posedge clk);
        m_step(v, ch, clr);
        #1;
        valid_in = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        #2;
        valid_in = 1'b1;
        char_in  = 8'h55;
        rst      = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_async_valid got=%b want=0", valid_out); end
        checks++; if (last_out !== 1'b0) begin failures++; $display("FAIL reset_async_last got=%b want=0", last_out); end
        checks++; if (index_out !== 8'h00) begin failures++; $display("FAIL reset_async_index got=%h want=00", index_out); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        m_reset();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_held_valid got=%b want=0", valid_out); end
        drive(1'b1, 8'h55, 1'b0);
        checks++; if (index_out !== 8'h55 || valid_out !== 1'b1) begin failures++; $display("FAIL reset_first_symbol got=%h/%b want=55/1", index_out, valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] syms [4];
        logic [7:0] want [4];
        syms = '{8'h61, 8'h62, 8'h61, 8'h61};
        want = '{8'h61, 8'h62, 8'h01, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, syms[i], 1'b0);
            checks++; if (index_out !== want[i] || valid_out !== 1'b1) begin failures++; $display("FAIL b2b_out[%0d] got=%h/%b want=%h/1", i, index_out, valid_out, want[i]); end
            checks++; if (index_out !== e_idx) begin failures++; $display("FAIL b2b_model[%0d] got=%h want=%h", i, index_out, e_idx); end
        end
        drive(1'b0, 8'h00, 1'b0);
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL b2b_trailing_valid got=%b want=0", valid_out); end
    endtask

    task automatic test_block_boundary();
        logic [7:0] want [5];
        logic       lw   [5];
        want = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h05};
        lw   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h05, 1'b0);
            checks++; if (index_out !== want[i] || last_out !== lw[i]) begin failures++; $display("FAIL boundary[%0d] got=%h/last=%b want=%h/last=%b", i, index_out, last_out, want[i], lw[i]); end
        end
    endtask

    task automatic test_full_depth();
        logic [7:0] syms [4];
        logic [7:0] want [4];
        syms = '{8'h03, 8'h01, 8'hFF, 8'h03};
        want = '{8'h03, 8'h02, 8'hFF, 8'h02};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, syms[i], 1'b0);
            checks++; if (index_out !== want[i]) begin failures++; $display("FAIL full_depth[%0d] got=%h want=%h", i, index_out, want[i]); end
        end
    endtask

    task automatic test_gap();
        do_reset();
        drive(1'b1, 8'h10, 1'b0);
        checks++; if (index_out !== 8'h10 || valid_out !== 1'b1) begin failures++; $display("FAIL gap_first got=%h/%b want=10/1", index_out, valid_out); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 8'hAA, 1'b0);
            checks++; if (valid_out !== 1'b0 || index_out !== 8'h10) begin failures++; $display("FAIL gap_hold[%0d] got=%h/%b want=10/0", i, index_out, valid_out); end
        end
        drive(1'b1, 8'h10, 1'b0);
        checks++; if (index_out !== 8'h00 || valid_out !== 1'b1) begin failures++; $display("FAIL gap_second got=%h/%b want=00/1", index_out, valid_out); end
    endtask

    task automatic test_clear();
        do_reset();
        drive(1'b1, 8'h20, 1'b0);
        drive(1'b1, 8'h07, 1'b1);
        checks++; if (valid_out !== 1'b0 || last_out !== 1'b0) begin failures++; $display("FAIL clear_wins got=%b/%b want=0/0", valid_out, last_out); end
        drive(1'b1, 8'h07, 1'b0);
        checks++; if (index_out !== 8'h07) begin failures++; $display("FAIL clear_identity got=%h want=07", index_out); end
        for (int i = 1; i < SL; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0);
            checks++; if (last_out !== (i == SL - 1)) begin failures++; $display("FAIL clear_cnt[%0d] last got=%b want=%b", i, last_out, (i == SL - 1)); end
            checks++; if (index_out !== e_idx) begin failures++; $display("FAIL clear_idx[%0d] got=%h want=%h", i, index_out, e_idx); end
        end
    endtask

    task automatic test_async_rst();
        do_reset();
        drive(1'b1, 8'h30, 1'b0);
        drive(1'b1, 8'h31, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0 || index_out !== 8'h00 || last_out !== 1'b0) begin failures++; $display("FAIL async_rst got=%h/%b/%b want=00/0/0", index_out, valid_out, last_out); end
        #1;
        rst = 1'b0;
        m_reset();
        drive(1'b1, 8'h42, 1'b0);
        checks++; if (index_out !== 8'h42 || valid_out !== 1'b1) begin failures++; $display("FAIL async_rst_next got=%h/%b want=42/1", index_out, valid_out); end
        for (int i = 0; i < SL - 1; i++) drive(1'b1, 8'h42, 1'b0);
        checks++; if (last_out !== 1'b1) begin failures++; $display("FAIL async_rst_block got=%b want=1", last_out); end
    endtask

    task automatic test_random();
        logic       v, c;
        logic [7:0] ch;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 24) == 0);
            ch = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            drive(v, ch, c);
            checks++;
            if (index_out !== e_idx || valid_out !== e_vld || last_out !== e_last) begin
                failures++;
                $display("FAIL random[%0d] got=%h/%b/%b want=%h/%b/%b", n, index_out, valid_out, last_out, e_idx, e_vld, e_last);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_back_to_back();
        test_block_boundary();
        test_full_depth();
        test_gap();
        test_clear();
        test_async_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtf_encoder.md
MTF_ENCODER -- requirements
Module: mtf_encoder

Interface
REQ-001 Parameter STRING_LEN, default 128: symbols per BWT block; legal range 2..256.
REQ-002 Parameter ALPHABET, fixed at 256: move-to-front table depth, one entry per 8-bit symbol.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 clear  input  1  synchronous block restart: table back to identity, symbol counter zeroed.
REQ-006 valid_in  input  1  char_in holds a BWT output symbol this cycle; driven from upstream valid_out.
REQ-007 char_in  input  8  BWT-transformed symbol.
REQ-008 index_out  output  8  MTF rank of the accepted symbol.
REQ-009 valid_out  output  1  index_out valid this cycle; single-cycle pulse per symbol.
REQ-010 last_out  output  1  asserted with valid_out on the STRING_LEN-th symbol of a block.

Function
REQ-011 Block SHALL hold table T[0..255] of 8-bit entries; T SHALL always be a permutation of 0..255.
REQ-012 Block SHALL have no backpressure and SHALL accept one symbol on every cycle that valid_in=1, including back-to-back cycles.
REQ-013 For an accepted symbol s, index k SHALL be the unique position with T[k]==s, found by a parallel compare across all entries in the accept cycle.
REQ-014 Same edge: T[0]<=s; T[i]<=T[i-1] for 1<=i<=k; T[i] unchanged for i>k.
REQ-015 k==0 SHALL leave T unchanged.
REQ-016 index_out<=k and valid_out<=1 on the accept edge: fixed latency 1 cycle, registered outputs.
REQ-017 Without an accept, valid_out and last_out SHALL be 0 on the next cycle and index_out SHALL hold its last value.
REQ-018 Symbol counter cnt, $clog2(STRING_LEN) bits (minimum 1), SHALL increment per accept.
REQ-019 Block boundary: on the accept with cnt==STRING_LEN-1, last_out<=1, cnt<=0, and T SHALL load identity (T[i]=i) instead of the REQ-014 update, so the next block starts from identity.
REQ-020 clear=1 SHALL load T to identity, set cnt<=0, and force valid_out<=0 and last_out<=0.
REQ-021 clear and valid_in both 1: clear SHALL win; the symbol SHALL be discarded with no output and no counter advance.
REQ-022 valid_in gaps mid-block SHALL NOT alter T or cnt.
REQ-023 Single state per cycle, no FSM beyond cnt; a new symbol in the cycle after an accept SHALL see the fully updated T (no stale-table hazard).

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, set T[i]=i for all i, cnt=0, index_out=0, valid_out=0, last_out=0.
REQ-025 Symbols presented while rst=1 SHALL be ignored; the first accept after rst deasserts SHALL be encoded against identity.
REQ-026 rst asserted mid-block SHALL abandon the partial block; no last_out SHALL be produced for it.

Verification
REQ-027 After reset, valid_in stream 0x61,0x62,0x61,0x61 back-to-back -> index_out 0x61,0x62,0x01,0x00 on consecutive cycles, each 1 cycle after input, valid_out high 4 cycles.
REQ-028 STRING_LEN=4, stream 0x05 x5 -> indices 0x05,0x00,0x00,0x00,0x05; last_out only with the 4th output.
REQ-029 After 0x03,0x01, the 0xFF symbol -> index 0xFF, then 0x03 -> index 0x02, verifying a full-depth shift.
REQ-030 valid_in pattern 1,0,0,1 with 0x10,0x10 -> outputs 0x10 then 0x00; valid_out low during the gap, index_out held.
REQ-031 clear and valid_in(0x07) in the same cycle mid-block -> no valid_out next cycle; a following 0x07 -> index 0x07 and cnt restarted (last_out after STRING_LEN further symbols).
REQ-032 rst pulsed asynchronously between clock edges mid-block -> outputs 0 before the next edge; the next symbol 0x42 -> index 0x42.
